// File: rtl/ntt_butterfly_ct_if.sv
// Handshake and data bundle for the NTT butterfly: fetch side (in_*) and
// write-back side (out_*). The master drives the inputs and consumes the results.
interface ntt_butterfly_ct_if #(
  parameter int W     = 12,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_zeta;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_even;
  logic [W-1:0]     out_odd;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_zeta, in_tag, out_ready,
    input  in_ready, out_valid, out_even, out_odd, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_zeta, in_tag, out_ready,
    output in_ready, out_valid, out_even, out_odd, out_tag
  );
endinterface

// File: rtl/ntt_butterfly_ct.sv
// Pipelined Cooley-Tukey butterfly for Kyber (q = 3329).
// t = b * zeta * 2^-12 mod q (Montgomery reduction), even = a + t, odd = a - t (mod q).
// Three register stages share a single advance enable, so a stalled output
// freezes the whole pipe and the input side sees in_ready low.
module ntt_butterfly_ct #(
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int QINV  = 3327,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ntt_butterfly_ct_if.slave bus
);
  localparam int STAGES = 3;
  localparam logic [W-1:0] Q_C    = W'(Q);
  localparam logic [W-1:0] QINV_C = W'(QINV);

  logic              adv;
  logic [STAGES-1:0] vld_pipe;

  // stage 1 registers: a, tag and the full 24-bit product b*zeta
  logic [W-1:0]     s1_a;
  logic [TAG_W-1:0] s1_tag;
  logic [2*W-1:0]   s1_prod;

  // stage 2 combinational Montgomery reduction
  logic [2*W-1:0] mq_prod;
  logic [W-1:0]   s2_m;
  logic [2*W:0]   red_sum;
  logic [W:0]     s2_u;
  logic [W-1:0]   s2_t_nxt;

  // stage 2 registers
  logic [W-1:0]     s2_a;
  logic [W-1:0]     s2_t;
  logic [TAG_W-1:0] s2_tag;

  // stage 3 combinational add/sub
  logic [W:0]   s3_sum;
  logic [W-1:0] s3_diff;
  logic [W-1:0] even_nxt;
  logic [W-1:0] odd_nxt;

  // stage 3 (output) registers
  logic [W-1:0]     out_even_q;
  logic [W-1:0]     out_odd_q;
  logic [TAG_W-1:0] out_tag_q;

  // The pipe moves when the output slot is empty or being drained.
  assign adv          = ~vld_pipe[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_even  = out_even_q;
  assign bus.out_odd   = out_odd_q;
  assign bus.out_tag   = out_tag_q;

  // m = (T * QINV) mod 2^12 only needs the low half of T.
  assign mq_prod = s1_prod[W-1:0] * QINV_C;
  assign s2_m    = mq_prod[W-1:0];
  // T + m*Q is an exact multiple of 2^12; keep the carry bit so nothing truncates.
  assign red_sum = {1'b0, s1_prod} + ({{(W+1){1'b0}}, s2_m} * {{(W+1){1'b0}}, Q_C});
  assign s2_u    = red_sum[2*W:W];
  assign s2_t_nxt = (s2_u >= {1'b0, Q_C}) ? W'(s2_u - {1'b0, Q_C}) : s2_u[W-1:0];

  assign s3_sum   = {1'b0, s2_a} + {1'b0, s2_t};
  assign even_nxt = (s3_sum >= {1'b0, Q_C}) ? W'(s3_sum - {1'b0, Q_C}) : s3_sum[W-1:0];
  // a - t wraps mod 2^12 when a < t; adding Q then lands back in 0..Q-1.
  assign s3_diff  = s2_a - s2_t;
  assign odd_nxt  = (s2_a < s2_t) ? s3_diff + Q_C : s3_diff;

  // valid shift register; bubbles travel as zeros, reset empties the pipe
  always_ff @(posedge clk) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-2:0], bus.in_valid};
  end

  // stage 1: capture operands and raw product
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a    <= '0;
      s1_tag  <= '0;
      s1_prod <= '0;
    end else if (adv) begin
      s1_a    <= bus.in_a;
      s1_tag  <= bus.in_tag;
      s1_prod <= bus.in_b * bus.in_zeta;
    end
  end

  // stage 2: capture reduced t alongside a and tag
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_a   <= '0;
      s2_t   <= '0;
      s2_tag <= '0;
    end else if (adv) begin
      s2_a   <= s1_a;
      s2_t   <= s2_t_nxt;
      s2_tag <= s1_tag;
    end
  end

  // stage 3: butterfly outputs, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_even_q <= '0;
      out_odd_q  <= '0;
      out_tag_q  <= '0;
    end else if (adv) begin
      out_even_q <= even_nxt;
      out_odd_q  <= odd_nxt;
      out_tag_q  <= s2_tag;
    end
  end
endmodule

// File: tb/tb_ntt_butterfly_ct.sv
// Bench for ntt_butterfly_ct: directed latency/boundary/stall/reset cases and a
// randomized run, all results scored against a plain modular-arithmetic model.
module tb_ntt_butterfly_ct;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int TAG_W = 8;

  typedef struct {
    int even;
    int odd;
    int tag;
  } exp_t;

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   inv_r;       // 4096^-1 mod Q
  int   out_cnt = 0;
  int   cyc = 0;
  int   first_out = -1;
  int   last_out  = -1;
  exp_t exp_q[$];

  ntt_butterfly_ct_if #(.W(W), .TAG_W(TAG_W)) bus ();

  ntt_butterfly_ct #(.W(W), .Q(Q), .QINV(3327), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, obs, exp);
  endtask

  function automatic exp_t model(input int a, input int b, input int z, input int tag);
    exp_t r;
    longint t;
    t = (longint'(b) * z) % Q;
    t = (t * inv_r) % Q;
    r.even = int'((a + t) % Q);
    r.odd  = int'((a - t + Q) % Q);
    r.tag  = tag;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: transfers are decided by the values standing before the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.in_a), int'(bus.in_b), int'(bus.in_zeta), int'(bus.in_tag)));
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_even", int'(bus.out_even), e.even);
          chk("sb_odd",  int'(bus.out_odd),  e.odd);
          chk("sb_tag",  int'(bus.out_tag),  e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one beat into an empty pipe; report outputs and cycles until out_valid
  task automatic single(input int a, input int b, input int z, input int tag,
                        output int e, output int o, output int lat);
    bus.out_ready = 1;
    bus.in_valid  = 1;
    bus.in_a      = W'(a);
    bus.in_b      = W'(b);
    bus.in_zeta   = W'(z);
    bus.in_tag    = TAG_W'(tag);
    tick();
    bus.in_valid = 0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    e = int'(bus.out_even);
    o = int'(bus.out_odd);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 0;
    bus.out_ready = 1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int e, o, lat, base, sent;
    int hold_e, hold_o, hold_t;
    bit acc;

    inv_r = 0;
    for (int i = 1; i < Q; i++) if ((i * 4096) % Q == 1) inv_r = i;

    rst = 1;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_zeta = '0; bus.in_tag = '0;
    bus.out_ready = 0;
    repeat (3) tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_even",      int'(bus.out_even),  0);
    chk("rst_odd",       int'(bus.out_odd),   0);
    chk("rst_tag",       int'(bus.out_tag),   0);
    rst = 0;
    tick();

    // T1: zeta = Montgomery 1, so t = b
    single(100, 200, 767, 1, e, o, lat);
    chk("t1_latency", lat, 3);
    chk("t1_even", e, 300);
    chk("t1_odd",  o, 3229);

    // T2: top-of-range wraparound and zero twiddle
    single(3328, 3328, 767, 2, e, o, lat);
    chk("t2_even_max", e, 3327);
    chk("t2_odd_max",  o, 0);
    single(5, 7, 0, 3, e, o, lat);
    chk("t2_even_z0", e, 5);
    chk("t2_odd_z0",  o, 5);

    // T3: 64 back-to-back beats with a free-running consumer
    first_out = -1;
    base = out_cnt;
    bus.out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1;
      bus.in_a = W'($urandom_range(0, Q-1));
      bus.in_b = W'($urandom_range(0, Q-1));
      bus.in_zeta = W'($urandom_range(0, Q-1));
      bus.in_tag = TAG_W'(i);
      chk("t3_in_ready", int'(bus.in_ready), 1);
      tick();
    end
    drain();
    chk("t3_count", out_cnt - base, 64);
    chk("t3_no_bubbles", last_out - first_out, 63);

    // T4: fill the pipe against a stalled consumer, then release
    base = out_cnt;
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1;
      bus.in_a = W'($urandom_range(0, Q-1));
      bus.in_b = W'($urandom_range(0, Q-1));
      bus.in_zeta = W'($urandom_range(0, Q-1));
      bus.in_tag = TAG_W'(8'h40 + i);
      tick();
    end
    bus.in_a = W'(1234); bus.in_b = W'(2345); bus.in_zeta = W'(3000); bus.in_tag = TAG_W'(8'h43);
    hold_e = int'(bus.out_even); hold_o = int'(bus.out_odd); hold_t = int'(bus.out_tag);
    for (int i = 0; i < 5; i++) begin
      chk("t4_out_valid", int'(bus.out_valid), 1);
      chk("t4_in_ready",  int'(bus.in_ready),  0);
      chk("t4_even_hold", int'(bus.out_even), hold_e);
      chk("t4_odd_hold",  int'(bus.out_odd),  hold_o);
      chk("t4_tag_hold",  int'(bus.out_tag),  hold_t);
      tick();
    end
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    drain();
    chk("t4_count", out_cnt - base, 4);

    // T5: reset with three beats in flight
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1;
      bus.in_a = W'($urandom_range(0, Q-1));
      bus.in_b = W'($urandom_range(0, Q-1));
      bus.in_zeta = W'($urandom_range(0, Q-1));
      bus.in_tag = TAG_W'(8'h50 + i);
      tick();
    end
    bus.in_valid = 0;
    rst = 1;
    tick();
    chk("t5_out_valid", int'(bus.out_valid), 0);
    chk("t5_in_ready",  int'(bus.in_ready),  1);
    rst = 0;
    base = out_cnt;
    repeat (8) tick();
    chk("t5_no_stale", out_cnt - base, 0);

    // T6: random traffic on both sides
    base = out_cnt;
    sent = 0;
    lat = 0;
    bus.in_valid = 0;
    while (sent < 10000 && lat < 60000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1;
        bus.in_a = ($urandom_range(0, 15) == 0) ? W'(Q-1) : W'($urandom_range(0, Q-1));
        bus.in_b = ($urandom_range(0, 15) == 0) ? W'(Q-1) : W'($urandom_range(0, Q-1));
        bus.in_zeta = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom_range(0, Q-1));
        bus.in_tag = TAG_W'(sent);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      tick();
      lat++;
      if (acc) bus.in_valid = 0;
    end
    chk("t6_sent", sent, 10000);
    drain();
    chk("t6_count", out_cnt - base, sent);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
